demux_led_sequencer: RTL and testbench
======================================

Name: demux_led_sequencer

Overview:
Controller that sequences the 1-to-4 LED demux on the Go Board, replacing direct switch-driven select lines. It consumes a one-cycle tick, normally the LFSR done pulse, and a mode-advance pulse. From these it generates registered select lines and the demux data bit for four display modes: MANUAL, CHASE, BOUNCE and SCAN. It sits between the LFSR tick source and the demux instance in the top level.

Parameters:
DWELL_TICKS, 2, accepted ticks spent at each position in CHASE/BOUNCE; must be >= 1.
MODE_RESET, 0, mode loaded at reset (0..3).

Ports:
i_Clk  input  1  system clock
i_Rst_L  input  1  reset, synchronous, active-low
i_Tick  input  1  single-cycle step strobe (LFSR done)
i_Mode_Next  input  1  single-cycle pulse; advance to next mode
i_Pause  input  1  level; freeze sequencing
i_Sel0  input  1  manual select bit 0 (switch)
i_Sel1  input  1  manual select bit 1 (switch)
o_Sel0  output  1  demux select bit 0
o_Sel1  output  1  demux select bit 1
o_Data  output  1  demux data bit
o_Mode  output  2  current mode
o_Step  output  1  one-cycle pulse when position advances in CHASE/BOUNCE

Behaviour:
- Clock and reset: one clock, i_Clk. Reset is synchronous and active-low on i_Rst_L. While i_Rst_L=0 at a rising edge, the next state is the reset state regardless of other inputs. This also applies mid-operation.
- Reset state: r_Mode=MODE_RESET, r_Pos=0, r_Dir=UP, r_Dwell=0, r_Blink=0, o_Step=0.
- Output mapping: {o_Sel1,o_Sel0}=r_Pos. o_Mode=r_Mode. o_Data=1 in CHASE/BOUNCE, otherwise r_Blink. All outputs derive from registers only, so there are no combinational input-to-output paths.
- Accepted tick: accepted_tick = i_Tick & ~i_Pause & ~i_Mode_Next.
- Mode change has priority:
  - When i_Mode_Next=1, the next cycle has r_Mode=r_Mode+1 (3 wraps to 0), r_Pos=0, r_Dwell=0, r_Dir=UP, r_Blink=0, o_Step=0.
  - A coincident tick is dropped.
  - i_Pause does not block a mode change.
- r_Blink toggles on each accepted tick in every mode.
- MANUAL (0):
  - r_Pos <= {i_Sel1,i_Sel0} every cycle unless paused, giving 1-cycle latency.
  - r_Dwell is unused and held at 0.
- CHASE (1):
  - On an accepted tick, if r_Dwell==DWELL_TICKS-1, then r_Dwell<=0, r_Pos<=r_Pos+1 (mod 4), and o_Step=1 for the next cycle.
  - Otherwise r_Dwell increments.
- BOUNCE (2):
  - Same dwell rule as CHASE.
  - Position advance follows r_Dir: UP increments and DOWN decrements.
  - At r_Pos=3 while UP, the move goes to 2 and r_Dir becomes DOWN.
  - At r_Pos=0 while DOWN, the move goes to 1 and r_Dir becomes UP.
  - Sequence: 0,1,2,3,2,1,0,1...
- SCAN (3):
  - r_Pos increments mod 4 every clock unless paused. This is not tick-gated.
  - o_Data=r_Blink, so all four LEDs appear to blink at a 25% duty cycle.
  - o_Step stays 0.
- Pause: i_Pause=1 holds r_Pos, r_Dwell, r_Dir and r_Blink. Ticks arriving during pause are lost, not queued.
- Latency: an event sampled at edge N is visible on the outputs after edge N.

Decomposition:
- Package demux_led_seq_pkg holds:
  - MODE_MANUAL=2'd0, MODE_CHASE=2'd1, MODE_BOUNCE=2'd2, MODE_SCAN=2'd3
  - DIR_UP=1'b0, DIR_DOWN=1'b1
  - mode typedef
- Sub-module dwell_counter, parameterized by DWELL_TICKS:
  - Inputs: clear, enable.
  - Output: a one-cycle wrap pulse that drives position advance and o_Step.
  - Counter width is $clog2(DWELL_TICKS), with a minimum of 1.

Test Plan:
- Reset: i_Rst_L=0 for 3 cycles with i_Tick=1 and i_Mode_Next=1 -> o_Mode=0, o_Sel1/0=00, o_Data=0, o_Step=0 throughout.
- CHASE, DWELL_TICKS=2: one mode pulse, then 8 ticks spaced 4 cycles apart -> o_Sel after each tick 0,1,1,2,2,3,3,0; o_Step pulses 4 times; o_Data=1.
- BOUNCE: two mode pulses, then 12 ticks -> o_Sel after each tick 0,1,1,2,2,3,3,2,2,1,1,0; o_Step pulses 6 times.
- MANUAL: i_Sel1/0=10 -> o_Sel=10 one cycle later; 3 ticks -> o_Data 1,0,1; i_Pause=1 with switches at 01 -> o_Sel stays 10.
- SCAN: o_Sel steps 0,1,2,3,0 on consecutive clocks; i_Pause=1 for 5 cycles -> o_Sel frozen; releasing pause resumes stepping from the frozen value.
- Collision: in CHASE with r_Dwell=1, i_Tick and i_Mode_Next in the same cycle -> o_Mode=2, o_Sel=0, no o_Step, r_Dwell=0.

Source files
------------

// File: rtl/demux_led_seq_pkg.sv
// Shared definitions for the LED demux sequencer.
// Contents: display mode encoding, bounce direction encoding.
package demux_led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_SCAN   = 2'd3
    } mode_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter: counts enabled cycles and reports when a position has been held
// for DWELL_TICKS accepted ticks.
// Ports:
//   i_Clk    - system clock
//   i_Rst_L  - synchronous active-low reset
//   i_Clear  - synchronous clear back to zero (mode change, non-dwelling modes)
//   i_Enable - one accepted tick
//   o_Wrap   - high in the cycle whose tick completes the dwell; the count
//              returns to zero on the same edge
module dwell_counter #(
    parameter int unsigned DWELL_TICKS = 2
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Clear,
    input  logic i_Enable,
    output logic o_Wrap
);

    localparam int unsigned CntW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DWELL_TICKS - 1);

    logic [CntW-1:0] r_Count;

    assign o_Wrap = i_Enable && (r_Count == CntMax);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L || i_Clear) begin
            r_Count <= '0;
        end else if (i_Enable) begin
            r_Count <= o_Wrap ? '0 : r_Count + 1'b1;
        end
    end

endmodule

// File: rtl/demux_led_sequencer.sv
// Sequencer driving the 1-to-4 LED demux select/data lines in four modes:
// MANUAL (switches), CHASE (0..3 ring), BOUNCE (0..3..0) and SCAN (fast
// rotation with blinking data). Tick normally comes from the LFSR done pulse.
// Ports:
//   i_Clk, i_Rst_L      - clock, synchronous active-low reset
//   i_Tick              - single-cycle step strobe
//   i_Mode_Next         - single-cycle pulse advancing the mode (wins over a tick)
//   i_Pause             - level, freezes position/dwell/direction/blink
//   i_Sel0, i_Sel1      - manual select switches
//   o_Sel0, o_Sel1      - demux select = current position
//   o_Data              - demux data bit
//   o_Mode              - current mode
//   o_Step              - one-cycle pulse after a CHASE/BOUNCE position advance
module demux_led_sequencer
    import demux_led_seq_pkg::*;
#(
    parameter int unsigned DWELL_TICKS = 2,
    parameter logic [1:0]  MODE_RESET  = 2'd0
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Tick,
    input  logic       i_Mode_Next,
    input  logic       i_Pause,
    input  logic       i_Sel0,
    input  logic       i_Sel1,
    output logic       o_Sel0,
    output logic       o_Sel1,
    output logic       o_Data,
    output logic [1:0] o_Mode,
    output logic       o_Step
);

    mode_t      r_Mode;
    logic [1:0] r_Pos;
    logic       r_Dir;
    logic       r_Blink;
    logic       r_Step;

    logic w_Accepted;
    logic w_Dwelling;
    logic w_Wrap;

    assign w_Accepted = i_Tick & ~i_Pause & ~i_Mode_Next;
    assign w_Dwelling = (r_Mode == MODE_CHASE) || (r_Mode == MODE_BOUNCE);

    // Dwell is only meaningful in CHASE/BOUNCE; hold it at zero elsewhere.
    dwell_counter #(
        .DWELL_TICKS (DWELL_TICKS)
    ) u_dwell (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Clear  (i_Mode_Next | ~w_Dwelling),
        .i_Enable (w_Accepted & w_Dwelling),
        .o_Wrap   (w_Wrap)
    );

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_Mode  <= mode_t'(MODE_RESET);
            r_Pos   <= 2'd0;
            r_Dir   <= DIR_UP;
            r_Blink <= 1'b0;
            r_Step  <= 1'b0;
        end else if (i_Mode_Next) begin
            // Mode change wins over pause and drops any coincident tick.
            r_Mode  <= mode_t'(r_Mode + 2'd1);
            r_Pos   <= 2'd0;
            r_Dir   <= DIR_UP;
            r_Blink <= 1'b0;
            r_Step  <= 1'b0;
        end else begin
            r_Step <= 1'b0;
            if (!i_Pause) begin
                if (i_Tick) begin
                    r_Blink <= ~r_Blink;
                end
                unique case (r_Mode)
                    MODE_MANUAL: r_Pos <= {i_Sel1, i_Sel0};
                    MODE_CHASE: begin
                        if (w_Wrap) begin
                            r_Pos  <= r_Pos + 2'd1;
                            r_Step <= 1'b1;
                        end
                    end
                    MODE_BOUNCE: begin
                        if (w_Wrap) begin
                            r_Step <= 1'b1;
                            if (r_Dir == DIR_UP) begin
                                if (r_Pos == 2'd3) begin
                                    r_Pos <= 2'd2;
                                    r_Dir <= DIR_DOWN;
                                end else begin
                                    r_Pos <= r_Pos + 2'd1;
                                end
                            end else begin
                                if (r_Pos == 2'd0) begin
                                    r_Pos <= 2'd1;
                                    r_Dir <= DIR_UP;
                                end else begin
                                    r_Pos <= r_Pos - 2'd1;
                                end
                            end
                        end
                    end
                    MODE_SCAN: r_Pos <= r_Pos + 2'd1;
                endcase
            end
        end
    end

    assign o_Sel0 = r_Pos[0];
    assign o_Sel1 = r_Pos[1];
    assign o_Mode = r_Mode;
    assign o_Data = w_Dwelling ? 1'b1 : r_Blink;
    assign o_Step = r_Step;

endmodule

// File: tb/tb_demux_led_sequencer.sv
module tb_demux_led_sequencer;

    logic       clk = 1'b0;
    logic       rst_l;
    logic       tick;
    logic       mode_next;
    logic       pause;
    logic       sel0_in;
    logic       sel1_in;
    logic       sel0_out;
    logic       sel1_out;
    logic       data;
    logic [1:0] mode;
    logic       step_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    demux_led_sequencer #(
        .DWELL_TICKS (2),
        .MODE_RESET  (2'd0)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_l),
        .i_Tick      (tick),
        .i_Mode_Next (mode_next),
        .i_Pause     (pause),
        .i_Sel0      (sel0_in),
        .i_Sel1      (sel1_in),
        .o_Sel0      (sel0_out),
        .o_Sel1      (sel1_out),
        .o_Data      (data),
        .o_Mode      (mode),
        .o_Step      (step_out)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] sel();
        return {2'b00, sel1_out, sel0_out};
    endfunction

    // One tick cycle followed by three idle cycles; returns o_Step seen across the four.
    task automatic spaced_tick(output int steps);
        steps = 0;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        if (step_out) steps++;
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (step_out) steps++;
        end
    endtask

    int chase_exp [8]   = '{0, 1, 1, 2, 2, 3, 3, 0};
    int bounce_exp [12] = '{0, 1, 1, 2, 2, 3, 3, 2, 2, 1, 1, 0};
    int scan_exp [5]    = '{1, 2, 3, 0, 1};
    int step_total;
    int s;

    initial begin
        // Reset held with tick and mode pulses asserted.
        rst_l = 1'b0; tick = 1'b1; mode_next = 1'b1; pause = 1'b0;
        sel0_in = 1'b0; sel1_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("rst_mode", {2'b00, mode}, 4'd0);
            check("rst_sel", sel(), 4'd0);
            check("rst_data", {3'b000, data}, 4'd0);
            check("rst_step", {3'b000, step_out}, 4'd0);
        end
        rst_l = 1'b1; tick = 1'b0; mode_next = 1'b0;
        cyc();

        // CHASE
        mode_next = 1'b1;
        cyc();
        mode_next = 1'b0;
        check("chase_mode", {2'b00, mode}, 4'd1);
        check("chase_data", {3'b000, data}, 4'd1);
        step_total = 0;
        for (int i = 0; i < 8; i++) begin
            spaced_tick(s);
            step_total += s;
            check($sformatf("chase_sel%0d", i), sel(), 4'(chase_exp[i]));
        end
        check("chase_steps", 4'(step_total), 4'd4);

        // Bring pos to 1 with dwell at 1, then collide tick with mode change.
        spaced_tick(s);
        spaced_tick(s);
        spaced_tick(s);
        check("pre_coll_sel", sel(), 4'd1);
        tick = 1'b1; mode_next = 1'b1;
        cyc();
        tick = 1'b0; mode_next = 1'b0;
        check("coll_mode", {2'b00, mode}, 4'd2);
        check("coll_sel", sel(), 4'd0);
        check("coll_step", {3'b000, step_out}, 4'd0);
        cyc();
        check("coll_step2", {3'b000, step_out}, 4'd0);

        // BOUNCE: first tick must not move, proving dwell was cleared.
        step_total = 0;
        for (int i = 0; i < 12; i++) begin
            spaced_tick(s);
            step_total += s;
            check($sformatf("bounce_sel%0d", i), sel(), 4'(bounce_exp[i]));
        end
        check("bounce_steps", 4'(step_total), 4'd6);

        // SCAN
        mode_next = 1'b1;
        cyc();
        mode_next = 1'b0;
        check("scan_mode", {2'b00, mode}, 4'd3);
        check("scan_sel0", sel(), 4'd0);
        check("scan_data0", {3'b000, data}, 4'd0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check($sformatf("scan_run%0d", i), sel(), 4'(scan_exp[i]));
            check("scan_step", {3'b000, step_out}, 4'd0);
        end
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick = (i == 2);
            cyc();
            check($sformatf("scan_pause%0d", i), sel(), 4'd1);
        end
        tick = 1'b0;
        check("scan_lost_tick", {3'b000, data}, 4'd0);
        pause = 1'b0;
        cyc();
        check("scan_resume1", sel(), 4'd2);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        check("scan_resume2", sel(), 4'd3);
        check("scan_blink", {3'b000, data}, 4'd1);

        // MANUAL (3 wraps to 0); switches at 10 during the mode pulse.
        sel1_in = 1'b1; sel0_in = 1'b0;
        mode_next = 1'b1;
        cyc();
        mode_next = 1'b0;
        check("man_mode", {2'b00, mode}, 4'd0);
        check("man_sel_at_change", sel(), 4'd0);
        check("man_data0", {3'b000, data}, 4'd0);
        cyc();
        check("man_sel", sel(), 4'd2);
        for (int i = 0; i < 3; i++) begin
            spaced_tick(s);
            check($sformatf("man_data%0d", i), {3'b000, data}, (i % 2 == 0) ? 4'd1 : 4'd0);
        end
        pause = 1'b1; sel1_in = 1'b0; sel0_in = 1'b1;
        cyc();
        cyc();
        check("man_pause_sel", sel(), 4'd2);

        // Pause does not block a mode change.
        mode_next = 1'b1;
        cyc();
        mode_next = 1'b0;
        check("pause_mode_chg", {2'b00, mode}, 4'd1);
        pause = 1'b0;

        // Mid-operation reset.
        tick = 1'b1; rst_l = 1'b0;
        cyc();
        check("midrst_mode", {2'b00, mode}, 4'd0);
        check("midrst_sel", sel(), 4'd0);
        check("midrst_data", {3'b000, data}, 4'd0);
        rst_l = 1'b1; tick = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
